tetris_sched: RTL and testbench
===============================

# tetris_sched

Command scheduler in front of the `tetris` core. It arbitrates three requesters onto the core's single `ctrl` input: buffered player keys, the gravity timer, and incoming garbage bars from the opponent link. It also sequences game start and restart. It issues a command only when the core reports `WAIT`, exactly one command per `WAIT` visit, and holds `bar_mask` stable for the core's `BAR` cycle.

## Interface
Parameters:
- `GRAVITY_TICKS`, default 50_000_000: clk cycles between gravity `DOWN`s; minimum 2.
- `KEY_DEPTH`, default 4: key FIFO entries (power of 2).
- `BAR_DEPTH`, default 4: garbage FIFO entries (power of 2).

Ports (types from `enum_type::state_type`):
- `clk` in 1: clock.
- `reset_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `game_state` in state_type: core `state` output.
- `start` in 1: one-cycle start/restart request.
- `pause` in 1: level; freezes issuing and gravity.
- `key_valid` in 1, `key_cmd` in state_type, `key_ready` out 1: key push; valid/ready handshake.
- `bar_valid` in 1, `bar_in` in 10: garbage push (1 = hole column).
- `bar_ready` out 1: garbage push ready.
- `ctrl` out state_type: command to core; registered.
- `bar_mask` out 10: garbage mask to core; registered.
- `issued` out 1: one-cycle pulse, aligned with `ctrl != NONE`.
- `issue_src` out 2: 0 key, 1 gravity, 2 bar, 3 start; valid with `issued`.

## Operation
- Reset values:
  - `ctrl=NONE`, `bar_mask=0`, `issued=0`, `issue_src=0`.
  - FIFOs empty, so `key_ready=1`, `bar_ready=1`.
  - Gravity counter and all pending flags cleared.
- Ready signals: `key_ready` = key FIFO not full; `bar_ready` = bar FIFO not full. Both are combinational from FIFO occupancy.
- Key acceptance: a push is accepted on `key_valid&key_ready`.
  - Only LEFT, RIGHT, ROTATE, ROTATE_REV, DOWN, DROP, HOLD are stored.
  - Any other value is accepted and discarded.
- Bar acceptance: a push is accepted on `bar_valid&bar_ready`. `bar_in==0` is accepted and discarded.
- Gravity: the counter increments each cycle while `game_state` is not in {INIT, END} and `pause==0`.
  - At `GRAVITY_TICKS-1` the counter wraps to 0 and sets `grav_pend`. `grav_pend` saturates and does not accumulate.
  - `game_state==GEN` clears both the counter and `grav_pend`.
  - Issuing a key DOWN or DROP clears both the counter and `grav_pend`.
- Issue FSM with states IDLE, ISSUE, HOLD_BAR:
  - IDLE → ISSUE when all of these hold: a source is pending, `pause==0`, `ctrl==NONE`, and `game_state==WAIT`.
  - ISSUE: drives the command for one cycle, then returns to IDLE. For BAR it goes to HOLD_BAR instead.
  - HOLD_BAR: holds `bar_mask` until `game_state` leaves BAR, then clears `bar_mask` to 0 and goes to IDLE.
- Priority: bar > gravity > key (fixed); the selected FIFO is popped on issue.
- Start/restart:
  - `start` sets `start_pend`.
  - With `game_state` in {INIT, END} and `ctrl==NONE`, the block issues `ctrl=DOWN` with `issue_src=3`. Pause is ignored for start.
  - `start_pend` clears only when the start is issued from INIT. This lets END→INIT→GEN complete from one `start`.
- Flush: `game_state==INIT` empties both FIFOs and clears `grav_pend`. A push in the same cycle is dropped.
- Simultaneous events: a push and a pop in the same cycle on a full FIFO is not allowed, because ready=0. On a non-empty FIFO, push and pop in the same cycle keeps the count unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight `ctrl` is lost.

## Timing
- `ctrl` is registered from `game_state` sampled at edge t. It is non-NONE during cycle t+1 only; the core consumes it at edge t+1.
- Issue latency: at least 1 cycle from a source becoming pending in WAIT; after each command, at least 1 cycle of `ctrl=NONE`.
- For BAR: `bar_mask` is valid from the `ctrl=BAR` cycle through the core's BAR cycle.
- Gravity period is exactly `GRAVITY_TICKS` cycles of unpaused, in-game time.

## Configuration
- `TETRIS_SCHED_DROP_FLUSH_EN` defined: issuing a key DROP also empties the key FIFO on the same edge, discarding moves queued for the old piece.
- Not defined: queued keys survive a DROP and apply to the next piece.

## Test plan
- Reset, `game_state=INIT`, pulse `start` → `ctrl=DOWN` for 1 cycle with `issue_src=3`; with `game_state` held at END, the same.
- In WAIT, push LEFT, RIGHT, ROTATE; toggle `game_state` WAIT→LEFT→MCHECK→WAIT each time → three single-cycle `ctrl` pulses in push order, with at least 1 NONE cycle between them.
- `GRAVITY_TICKS=8`, WAIT, keys pending, `bar_in=10'b0000010000` pushed → issue order BAR (`bar_mask=0x010` held through BAR), then DOWN (src 1), then key.
- Push 5 keys with `KEY_DEPTH=4` and `game_state≠WAIT` → 5th push sees `key_ready=0`; `key_cmd=BAR` pushed after draining → discarded, never issued.
- `pause=1` for 20 cycles in WAIT with `GRAVITY_TICKS=8` → no issue, counter frozen; release → DOWN after 8 more cycles.
- With `TETRIS_SCHED_DROP_FLUSH_EN`, queue DROP, LEFT → only DROP issued, FIFO empty; without the macro, LEFT issues at the next WAIT.

Source files
------------

// File: rtl/tetris_sched.sv
// +--------------------------------------------------------------------------+
// | tetris_sched: arbitrates keys, gravity and garbage bars onto tetris ctrl. |
// | Option: TETRIS_SCHED_DROP_FLUSH_EN (key DROP empties key FIFO). Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

package enum_type;
  typedef enum logic [3:0] {
    NONE, INIT, GEN, WAIT, LEFT, RIGHT, ROTATE, ROTATE_REV,
    DOWN, DROP, HOLD, MCHECK, RCHECK, BAR, CLEAR, END
  } state_type;
endpackage

module tetris_sched
  import enum_type::*;
#(
  parameter int GRAVITY_TICKS = 50_000_000,
  parameter int KEY_DEPTH     = 4,
  parameter int BAR_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  state_type   game_state,
  input  logic        start,
  input  logic        pause,
  input  logic        key_valid,
  input  state_type   key_cmd,
  output logic        key_ready,
  input  logic        bar_valid,
  input  logic [9:0]  bar_in,
  output logic        bar_ready,
  output state_type   ctrl,
  output logic [9:0]  bar_mask,
  output logic        issued,
  output logic [1:0]  issue_src
);

  localparam int KAW = $clog2(KEY_DEPTH);
  localparam int BAW = $clog2(BAR_DEPTH);
  localparam int CW  = $clog2(GRAVITY_TICKS);
  localparam logic [CW-1:0] GRAV_LAST = CW'(GRAVITY_TICKS - 1);
  localparam logic [CW-1:0] GRAV_ONE  = CW'(1);
  localparam logic [KAW:0]  KPTR_ONE  = (KAW + 1)'(1);
  localparam logic [BAW:0]  BPTR_ONE  = (BAW + 1)'(1);

  localparam logic [1:0] SRC_KEY   = 2'd0;
  localparam logic [1:0] SRC_GRAV  = 2'd1;
  localparam logic [1:0] SRC_BAR   = 2'd2;
  localparam logic [1:0] SRC_START = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD_BAR} fsm_t;

  fsm_t        st_q, st_d;
  state_type   ctrl_q, ctrl_d;
  logic [9:0]  mask_q, mask_d;
  logic        issued_q, issued_d;
  logic [1:0]  src_q, src_d;
  logic        start_pend_q, start_pend_d;
  logic        grav_pend_q, grav_pend_d;
  logic [CW-1:0] grav_cnt_q, grav_cnt_d;

  state_type   key_mem_q [KEY_DEPTH];
  logic [KAW:0] key_wr_q, key_rd_q;
  logic [9:0]  bar_mem_q [BAR_DEPTH];
  logic [BAW:0] bar_wr_q, bar_rd_q;

  logic        key_empty, key_full, bar_empty, bar_full;
  logic        key_push, key_pop, key_flush;
  logic        bar_push, bar_pop, bar_flush;
  state_type   key_head;
  logic [9:0]  bar_head;
  logic        start_go, play_go, issue_go, key_moves_piece_down;
  logic [1:0]  sel_src;
  state_type   sel_cmd;
  logic        grav_run;

  function automatic logic is_move(input state_type c);
    case (c)
      LEFT, RIGHT, ROTATE, ROTATE_REV, DOWN, DROP, HOLD: is_move = 1'b1;
      default:                                           is_move = 1'b0;
    endcase
  endfunction

  assign key_empty = (key_wr_q == key_rd_q);
  assign key_full  = (key_wr_q[KAW] != key_rd_q[KAW]) &&
                     (key_wr_q[KAW-1:0] == key_rd_q[KAW-1:0]);
  assign bar_empty = (bar_wr_q == bar_rd_q);
  assign bar_full  = (bar_wr_q[BAW] != bar_rd_q[BAW]) &&
                     (bar_wr_q[BAW-1:0] == bar_rd_q[BAW-1:0]);
  assign key_head  = key_mem_q[key_rd_q[KAW-1:0]];
  assign bar_head  = bar_mem_q[bar_rd_q[BAW-1:0]];

  assign key_ready = !key_full;
  assign bar_ready = !bar_full;

  // Start lives only in INIT/END, play issues only in WAIT, so they never collide.
  assign start_go = (st_q == S_IDLE) && (ctrl_q == NONE) && start_pend_q &&
                    ((game_state == INIT) || (game_state == END));
  assign play_go  = (st_q == S_IDLE) && (ctrl_q == NONE) && !pause &&
                    (game_state == WAIT) && (!bar_empty || grav_pend_q || !key_empty);
  assign issue_go = start_go || play_go;

  always_comb begin
    sel_src = SRC_KEY;
    sel_cmd = NONE;
    if (start_go) begin
      sel_src = SRC_START;
      sel_cmd = DOWN;
    end else if (!bar_empty) begin
      sel_src = SRC_BAR;
      sel_cmd = BAR;
    end else if (grav_pend_q) begin
      sel_src = SRC_GRAV;
      sel_cmd = DOWN;
    end else begin
      sel_src = SRC_KEY;
      sel_cmd = key_head;
    end
  end

  assign key_pop  = issue_go && (sel_src == SRC_KEY);
  assign bar_pop  = issue_go && (sel_src == SRC_BAR);
  assign key_moves_piece_down = key_pop && ((key_head == DOWN) || (key_head == DROP));

`ifdef TETRIS_SCHED_DROP_FLUSH_EN
  assign key_flush = (game_state == INIT) || (key_pop && (key_head == DROP));
`else
  assign key_flush = (game_state == INIT);
`endif
  assign bar_flush = (game_state == INIT);

  assign key_push = key_valid && !key_full && is_move(key_cmd) && !key_flush;
  assign bar_push = bar_valid && !bar_full && (bar_in != 10'd0) && !bar_flush;

  always_ff @(posedge clk) begin
    if (key_push) key_mem_q[key_wr_q[KAW-1:0]] <= key_cmd;
    if (bar_push) bar_mem_q[bar_wr_q[BAW-1:0]] <= bar_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_wr_q <= '0;
      key_rd_q <= '0;
      bar_wr_q <= '0;
      bar_rd_q <= '0;
    end else begin
      if (key_flush) begin
        key_wr_q <= '0;
        key_rd_q <= '0;
      end else begin
        if (key_push) key_wr_q <= key_wr_q + KPTR_ONE;
        if (key_pop)  key_rd_q <= key_rd_q + KPTR_ONE;
      end
      if (bar_flush) begin
        bar_wr_q <= '0;
        bar_rd_q <= '0;
      end else begin
        if (bar_push) bar_wr_q <= bar_wr_q + BPTR_ONE;
        if (bar_pop)  bar_rd_q <= bar_rd_q + BPTR_ONE;
      end
    end
  end

  assign grav_run = (game_state != INIT) && (game_state != END) && !pause;

  always_comb begin
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = grav_pend_q;
    if (issue_go && (sel_src == SRC_GRAV)) grav_pend_d = 1'b0;
    if (grav_run) begin
      if (grav_cnt_q == GRAV_LAST) begin
        grav_cnt_d  = '0;
        grav_pend_d = 1'b1;
      end else begin
        grav_cnt_d  = grav_cnt_q + GRAV_ONE;
      end
    end
    if (key_moves_piece_down || (game_state == GEN)) begin
      grav_cnt_d  = '0;
      grav_pend_d = 1'b0;
    end
    if (game_state == INIT) grav_pend_d = 1'b0;
  end

  always_comb begin
    start_pend_d = start_pend_q;
    if (start) start_pend_d = 1'b1;
    else if (start_go && (game_state == INIT)) start_pend_d = 1'b0;
  end

  always_comb begin
    st_d     = st_q;
    ctrl_d   = NONE;
    issued_d = 1'b0;
    src_d    = src_q;
    mask_d   = mask_q;
    case (st_q)
      S_IDLE: begin
        if (issue_go) begin
          st_d     = S_ISSUE;
          ctrl_d   = sel_cmd;
          issued_d = 1'b1;
          src_d    = sel_src;
          if (sel_src == SRC_BAR) mask_d = bar_head;
        end
      end
      S_ISSUE: st_d = (src_q == SRC_BAR) ? S_HOLD_BAR : S_IDLE;
      S_HOLD_BAR: begin
        if (game_state != BAR) begin
          mask_d = '0;
          st_d   = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= S_IDLE;
      ctrl_q       <= NONE;
      mask_q       <= '0;
      issued_q     <= 1'b0;
      src_q        <= SRC_KEY;
      start_pend_q <= 1'b0;
      grav_pend_q  <= 1'b0;
      grav_cnt_q   <= '0;
    end else begin
      st_q         <= st_d;
      ctrl_q       <= ctrl_d;
      mask_q       <= mask_d;
      issued_q     <= issued_d;
      src_q        <= src_d;
      start_pend_q <= start_pend_d;
      grav_pend_q  <= grav_pend_d;
      grav_cnt_q   <= grav_cnt_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign bar_mask  = mask_q;
  assign issued    = issued_q;
  assign issue_src = src_q;

endmodule

`default_nettype wire

// File: tb/tb_tetris_sched.sv
// +--------------------------------------------------------------------------+
// | tb_tetris_sched: directed self-checking bench, GRAVITY_TICKS=8.  Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tetris_sched;
  import enum_type::*;

  logic       clk;
  logic       reset_n;
  state_type  game_state;
  logic       start;
  logic       pause;
  logic       key_valid;
  state_type  key_cmd;
  logic       key_ready;
  logic       bar_valid;
  logic [9:0] bar_in;
  logic       bar_ready;
  state_type  ctrl;
  logic [9:0] bar_mask;
  logic       issued;
  logic [1:0] issue_src;

  int n_cmp = 0;
  int n_bad = 0;

  tetris_sched #(
    .GRAVITY_TICKS(8),
    .KEY_DEPTH(4),
    .BAR_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .game_state(game_state),
    .start(start),
    .pause(pause),
    .key_valid(key_valid),
    .key_cmd(key_cmd),
    .key_ready(key_ready),
    .bar_valid(bar_valid),
    .bar_in(bar_in),
    .bar_ready(bar_ready),
    .ctrl(ctrl),
    .bar_mask(bar_mask),
    .issued(issued),
    .issue_src(issue_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (ctrl !== NONE) begin n_bad++; $display("FAIL reset_ctrl: got %0d want %0d", ctrl, NONE); end
    n_cmp++; if (bar_mask !== 10'd0) begin n_bad++; $display("FAIL reset_mask: got %h want 000", bar_mask); end
    n_cmp++; if (issued !== 1'b0) begin n_bad++; $display("FAIL reset_issued: got %b want 0", issued); end
    n_cmp++; if (issue_src !== 2'd0) begin n_bad++; $display("FAIL reset_src: got %0d want 0", issue_src); end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    n_cmp++; if (bar_ready !== 1'b1) begin n_bad++; $display("FAIL reset_bar_ready: got %b want 1", bar_ready); end
  endtask

  task automatic test_start_init();
    game_state = INIT;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (issued !== 1'b0) begin n_bad++; $display("FAIL start_init_early: got %b want 0", issued); end
    tick();
    n_cmp++; if (ctrl !== DOWN) begin n_bad++; $display("FAIL start_init_ctrl: got %0d want %0d", ctrl, DOWN); end
    n_cmp++; if (issued !== 1'b1) begin n_bad++; $display("FAIL start_init_issued: got %b want 1", issued); end
    n_cmp++; if (issue_src !== 2'd3) begin n_bad++; $display("FAIL start_init_src: got %0d want 3", issue_src); end
    tick();
    n_cmp++; if (ctrl !== NONE) begin n_bad++; $display("FAIL start_init_gap: got %0d want %0d", ctrl, NONE); end
    tick();
    tick();
    n_cmp++; if (issued !== 1'b0) begin n_bad++; $display("FAIL start_init_once: got %b want 0", issued); end
  endtask

  task automatic test_start_end();
    game_state = END;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (ctrl !== DOWN) begin n_bad++; $display("FAIL start_end_ctrl: got %0d want %0d", ctrl, DOWN); end
    n_cmp++; if (issue_src !== 2'd3) begin n_bad++; $display("FAIL start_end_src: got %0d want 3", issue_src); end
    game_state = INIT;
    tick();
    n_cmp++; if (ctrl !== NONE) begin n_bad++; $display("FAIL start_end_gap: got %0d want %0d", ctrl, NONE); end
    tick();
    n_cmp++; if (ctrl !== DOWN) begin n_bad++; $display("FAIL start_end_reissue: got %0d want %0d", ctrl, DOWN); end
    n_cmp++; if (issue_src !== 2'd3) begin n_bad++; $display("FAIL start_end_reissue_src: got %0d want 3", issue_src); end
    tick();
    tick();
    n_cmp++; if (issued !== 1'b0) begin n_bad++; $display("FAIL start_end_cleared: got %b want 0", issued); end
  endtask

  task automatic test_key_order();
    game_state = GEN;
    key_valid = 1'b1;
    key_cmd = LEFT;   tick();
    key_cmd = RIGHT;  tick();
    key_cmd = ROTATE; tick();
    key_valid = 1'b0;
    game_state = WAIT;
    tick();
    n_cmp++; if (ctrl !== LEFT) begin n_bad++; $display("FAIL key_order_1: got %0d want %0d", ctrl, LEFT); end
    n_cmp++; if (issue_src !== 2'd0) begin n_bad++; $display("FAIL key_order_src: got %0d want 0", issue_src); end
    game_state = LEFT;
    tick();
    n_cmp++; if (ctrl !== NONE) begin n_bad++; $display("FAIL key_order_gap: got %0d want %0d", ctrl, NONE); end
    game_state = MCHECK; tick();
    game_state = WAIT;   tick();
    n_cmp++; if (ctrl !== RIGHT) begin n_bad++; $display("FAIL key_order_2: got %0d want %0d", ctrl, RIGHT); end
    game_state = LEFT;   tick();
    game_state = MCHECK; tick();
    game_state = WAIT;   tick();
    n_cmp++; if (ctrl !== ROTATE) begin n_bad++; $display("FAIL key_order_3: got %0d want %0d", ctrl, ROTATE); end
    game_state = GEN;
    tick();
  endtask

  task automatic test_priority();
    game_state = GEN;
    key_valid = 1'b1; key_cmd = LEFT;
    bar_valid = 1'b1; bar_in = 10'h010;
    tick();
    key_cmd = RIGHT;
    bar_in = 10'h000;
    tick();
    key_valid = 1'b0;
    bar_valid = 1'b0;
    game_state = MCHECK;
    repeat (8) tick();
    game_state = WAIT;
    tick();
    n_cmp++; if (ctrl !== BAR) begin n_bad++; $display("FAIL prio_bar_ctrl: got %0d want %0d", ctrl, BAR); end
    n_cmp++; if (bar_mask !== 10'h010) begin n_bad++; $display("FAIL prio_bar_mask: got %h want 010", bar_mask); end
    n_cmp++; if (issue_src !== 2'd2) begin n_bad++; $display("FAIL prio_bar_src: got %0d want 2", issue_src); end
    tick();
    n_cmp++; if (bar_mask !== 10'h010) begin n_bad++; $display("FAIL prio_mask_hold1: got %h want 010", bar_mask); end
    game_state = BAR;
    tick();
    tick();
    n_cmp++; if (bar_mask !== 10'h010) begin n_bad++; $display("FAIL prio_mask_in_bar: got %h want 010", bar_mask); end
    n_cmp++; if (issued !== 1'b0) begin n_bad++; $display("FAIL prio_no_issue_in_bar: got %b want 0", issued); end
    game_state = WAIT;
    tick();
    n_cmp++; if (bar_mask !== 10'h000) begin n_bad++; $display("FAIL prio_mask_clear: got %h want 000", bar_mask); end
    tick();
    n_cmp++; if (ctrl !== DOWN) begin n_bad++; $display("FAIL prio_grav_ctrl: got %0d want %0d", ctrl, DOWN); end
    n_cmp++; if (issue_src !== 2'd1) begin n_bad++; $display("FAIL prio_grav_src: got %0d want 1", issue_src); end
    game_state = GEN;
    tick();
    game_state = WAIT;
    tick();
    n_cmp++; if (ctrl !== LEFT) begin n_bad++; $display("FAIL prio_key_ctrl: got %0d want %0d", ctrl, LEFT); end
    n_cmp++; if (issue_src !== 2'd0) begin n_bad++; $display("FAIL prio_key_src: got %0d want 0", issue_src); end
    game_state = INIT;
    tick();
  endtask

  task automatic test_full_discard();
    state_type cmds [4];
    logic      seen;
    cmds[0] = LEFT; cmds[1] = RIGHT; cmds[2] = ROTATE; cmds[3] = ROTATE_REV;
    game_state = GEN;
    key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_cmd = cmds[i];
      tick();
    end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_after4: got %b want 0", key_ready); end
    key_cmd = HOLD;
    tick();
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_5th: got %b want 0", key_ready); end
    key_valid = 1'b0;
    game_state = WAIT;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (ctrl !== cmds[i]) begin n_bad++; $display("FAIL drain_%0d: got %0d want %0d", i, ctrl, cmds[i]); end
      tick();
    end
    game_state = GEN;
    key_valid = 1'b1;
    key_cmd = BAR;
    tick();
    key_valid = 1'b0;
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL discard_ready: got %b want 1", key_ready); end
    game_state = WAIT;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (issued) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL discard_never_issued: got %b want 0", seen); end
  endtask

  task automatic test_pause();
    logic seen;
    game_state = GEN;
    tick();
    game_state = WAIT;
    pause = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (issued) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL pause_no_issue: got %b want 0", seen); end
    pause = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (issued) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL pause_frozen: got %b want 0", seen); end
    tick();
    n_cmp++; if (ctrl !== DOWN) begin n_bad++; $display("FAIL pause_release_ctrl: got %0d want %0d", ctrl, DOWN); end
    n_cmp++; if (issue_src !== 2'd1) begin n_bad++; $display("FAIL pause_release_src: got %0d want 1", issue_src); end
    game_state = GEN;
    tick();
  endtask

  task automatic test_drop();
    game_state = GEN;
    key_valid = 1'b1;
    key_cmd = DROP; tick();
    key_cmd = LEFT; tick();
    key_valid = 1'b0;
    game_state = WAIT;
    tick();
    n_cmp++; if (ctrl !== DROP) begin n_bad++; $display("FAIL drop_ctrl: got %0d want %0d", ctrl, DROP); end
    game_state = GEN;
    tick();
    game_state = WAIT;
    tick();
`ifdef TETRIS_SCHED_DROP_FLUSH_EN
    n_cmp++; if (issued !== 1'b0) begin n_bad++; $display("FAIL drop_flushed: got %b want 0", issued); end
`else
    n_cmp++; if (ctrl !== LEFT) begin n_bad++; $display("FAIL drop_keeps_left: got %0d want %0d", ctrl, LEFT); end
`endif
    game_state = GEN;
    tick();
  endtask

  task automatic test_reset_mid();
    game_state = GEN;
    key_valid = 1'b1;
    key_cmd = RIGHT;
    tick();
    key_valid = 1'b0;
    game_state = WAIT;
    tick();
    n_cmp++; if (ctrl !== RIGHT) begin n_bad++; $display("FAIL mid_pre_ctrl: got %0d want %0d", ctrl, RIGHT); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (ctrl !== NONE) begin n_bad++; $display("FAIL mid_reset_ctrl: got %0d want %0d", ctrl, NONE); end
    n_cmp++; if (issued !== 1'b0) begin n_bad++; $display("FAIL mid_reset_issued: got %b want 0", issued); end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    game_state = INIT;
    start      = 1'b0;
    pause      = 1'b0;
    key_valid  = 1'b0;
    key_cmd    = NONE;
    bar_valid  = 1'b0;
    bar_in     = 10'd0;
    tick();
    tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_start_init();
    test_start_end();
    test_key_order();
    test_priority();
    test_full_discard();
    test_pause();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
